atm_controller: RTL and testbench
=================================

# atm_controller

ATM transaction controller: the responder side of the card/PIN/amount interface driven by the ATM bench stimulus. It accepts a card-present indication, collects a 4-digit PIN one strobed digit at a time, and compares it to the card's PIN. On a correct PIN it executes one deposit or withdrawal against a 64-bit balance. It tracks failed PIN attempts through warning and lockout.

## Interface
- `TIMEOUT_CYC`, 1000: idle cycles allowed between PIN digits; used only with `ATM_PIN_TIMEOUT_EN`.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `TARJETA_RECIBIDA`  in  1  card present, level.
- `TIPO_TRANS`  in  1  0 = deposit, 1 = withdrawal; sampled with the `MONTO_STB` edge.
- `MONTO_STB`  in  1  amount strobe, may be held multiple cycles.
- `DIGITO_STB`  in  1  digit strobe, may be held multiple cycles.
- `DIGITO`  in  4  BCD digit; sampled with the `DIGITO_STB` edge.
- `PIN`  in  16  correct PIN, 4 BCD digits, first digit in [15:12].
- `MONTO`  in  32  transaction amount, unsigned.
- `BALANCE_INICIAL`  in  64  card balance, loaded on session start.
- `BALANCE`  out  64  current balance.
- `BALANCE_ACTUALIZADO`  out  1  one-cycle pulse when `BALANCE` is written.
- `ENTREGAR_DINERO`  out  1  one-cycle pulse on a successful withdrawal.
- `PIN_INCORRECTO`  out  1  one-cycle pulse per wrong PIN.
- `ADVERTENCIA`  out  1  level; high after 2 consecutive wrong PINs.
- `BLOQUEO`  out  1  level; high after 3 wrong PINs, held until reset.
- `FONDOS_INSUFICIENTES`  out  1  one-cycle pulse when a withdrawal is refused.

## Operation
- **Strobe detection.** Each strobe is registered, and a strobe "edge" is strobe=1 while its registered copy is 0. Each held strobe is therefore consumed once.
- **States:** IDLE, PIN_ENTRY, CHECK_PIN, WAIT_TRANS, EXEC, DONE, BLOCKED.
- **IDLE.** When `TARJETA_RECIBIDA`=1, load `BALANCE`←`BALANCE_INICIAL`, clear the digit register and digit count, then go to PIN_ENTRY.
- **PIN_ENTRY.**
  - Each `DIGITO_STB` edge shifts `DIGITO` into a 16-bit register, MSB first, and increments a 2-bit count.
  - On the 4th digit, go to CHECK_PIN.
  - `TARJETA_RECIBIDA`=0 returns to IDLE and discards the partial digits; this is not an attempt.
- **CHECK_PIN.**
  - **Match:** clear the attempt counter, deassert `ADVERTENCIA`, go to WAIT_TRANS.
  - **Mismatch:** pulse `PIN_INCORRECTO` and increment the attempt counter.
    - Counter=2: set `ADVERTENCIA`.
    - Counter=3: set `BLOQUEO` and go to BLOCKED.
    - Otherwise: go to PIN_ENTRY with the digits cleared.
- **WAIT_TRANS.** A `MONTO_STB` edge captures `MONTO` and `TIPO_TRANS`, then go to EXEC. Card removal returns to IDLE.
- **EXEC.**
  - **Deposit:** `BALANCE`←`BALANCE`+{32'b0,`MONTO`}, wrapping modulo 2^64; pulse `BALANCE_ACTUALIZADO`.
  - **Withdrawal with `MONTO`≤`BALANCE`:** subtract; pulse `BALANCE_ACTUALIZADO` and `ENTREGAR_DINERO`. Equality is allowed and leaves a balance of 0.
  - **Withdrawal with `MONTO`>`BALANCE`:** pulse `FONDOS_INSUFICIENTES`; the balance is unchanged.
  - Always go to DONE.
- **DONE.** Wait for `TARJETA_RECIBIDA`=0, then go to IDLE. Exactly one transaction is allowed per session.
- **BLOCKED.** Absorbing: all strobes are ignored, and only `rst` exits.
- **Attempt counter.** Persists across card removal and is cleared only by a correct PIN or by reset.

## Timing
- **Reset values:** all outputs 0, `BALANCE`=0, state IDLE, attempt counter 0, digit register 0.
- **Reset mid-operation:** the async assert clears everything immediately, including `BLOQUEO`.
- **PIN check:** the 4th-digit edge is sampled at clock N. CHECK_PIN executes at N+1, and `PIN_INCORRECTO`/`ADVERTENCIA`/`BLOQUEO` are visible after edge N+1.
- **Transaction:** the `MONTO_STB` edge is sampled at clock M. EXEC runs at M+1, and `BALANCE` plus the result pulses are visible after edge M+1. Each pulse is exactly one cycle.
- **Ignored strobes:** `DIGITO_STB` outside PIN_ENTRY and `MONTO_STB` outside WAIT_TRANS.
- **Simultaneous strobes:** both strobes in the same cycle are allowed; each is judged only by its own state.
- **Card removal vs. strobe in one cycle:** card removal has priority.
- **Output registers:** all outputs are registered, with no combinational input-to-output paths.

## Configuration
- **`ATM_PIN_TIMEOUT_EN` defined:**
  - A counter runs in PIN_ENTRY and resets on each digit edge.
  - After `TIMEOUT_CYC` cycles without a digit, the block returns to PIN_ENTRY with the digits cleared.
  - A timeout is not counted as an attempt and pulses no outputs.
- **Undefined:** PIN_ENTRY waits indefinitely, and no counter is synthesized.

## Test plan
- **Deposit:** `PIN`=16'h3761, `BALANCE_INICIAL`=10000; card in, digits 3,7,6,1, `TIPO_TRANS`=0, `MONTO`=2000 with a 2-cycle strobe → `BALANCE`=12000, a single `BALANCE_ACTUALIZADO` pulse, `ENTREGAR_DINERO`=0.
- **Withdrawal:** same PIN, `TIPO_TRANS`=1, `MONTO`=2500 → `BALANCE`=7500, `BALANCE_ACTUALIZADO` and `ENTREGAR_DINERO` each pulse once. A second withdrawal of `MONTO`=7500 in a new session (`BALANCE_INICIAL`=7500) → `BALANCE`=0.
- **Insufficient funds:** `MONTO`=15000, withdrawal → `FONDOS_INSUFICIENTES` pulse, `BALANCE`=10000, no `ENTREGAR_DINERO`.
- **Lockout:** digits 1,1,1,1 → `PIN_INCORRECTO` pulse. 2,2,2,2 → pulse plus `ADVERTENCIA`=1. 4,4,4,4 → `BLOQUEO`=1. Further digits plus a correct PIN → no response. `rst`=0 → all outputs 0.
- **Reset mid-PIN:** reset after digits 3,7, then enter 3,7,6,1 → PIN accepted, reaches WAIT_TRANS. Card removed mid-PIN → the next 4 correct digits are accepted.
- **Timeout (`ATM_PIN_TIMEOUT_EN`):** digits 3,7, idle `TIMEOUT_CYC` cycles, then 3,7,6,1 → accepted, `PIN_INCORRECTO` never pulses.

Source files
------------

// File: rtl/atm_controller.sv
// rtl/atm_controller.sv - ATM card/PIN/amount responder with attempt lockout
// Optional PIN inter-digit timeout enabled by defining ATM_PIN_TIMEOUT_EN.
module atm_controller
`ifdef ATM_PIN_TIMEOUT_EN
  #(parameter int TIMEOUT_CYC = 1000)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        TARJETA_RECIBIDA,
  input  logic        TIPO_TRANS,
  input  logic        MONTO_STB,
  input  logic        DIGITO_STB,
  input  logic [3:0]  DIGITO,
  input  logic [15:0] PIN,
  input  logic [31:0] MONTO,
  input  logic [63:0] BALANCE_INICIAL,
  output logic [63:0] BALANCE,
  output logic        BALANCE_ACTUALIZADO,
  output logic        ENTREGAR_DINERO,
  output logic        PIN_INCORRECTO,
  output logic        ADVERTENCIA,
  output logic        BLOQUEO,
  output logic        FONDOS_INSUFICIENTES
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PIN_ENTRY, ST_CHECK_PIN, ST_WAIT_TRANS, ST_EXEC, ST_DONE, ST_BLOCKED
  } state_t;

  state_t      state, state_n;
  logic        digito_q, monto_q;
  logic        digito_edge, monto_edge;
  logic [15:0] digits, digits_n;
  logic [1:0]  dig_cnt, cnt_n;
  logic [1:0]  attempts, att_n;
  logic [31:0] monto_r, monto_n;
  logic        tipo_r, tipo_n;
  logic [63:0] bal_n;
  logic        act_n, ent_n, inc_n, adv_n, blk_n, fon_n;

`ifdef ATM_PIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt, tmo_n;
`endif

  assign digito_edge = DIGITO_STB & ~digito_q;
  assign monto_edge  = MONTO_STB & ~monto_q;

  always_comb begin
    state_n = state;
    digits_n = digits;
    cnt_n = dig_cnt;
    att_n = attempts;
    monto_n = monto_r;
    tipo_n = tipo_r;
    bal_n = BALANCE;
    adv_n = ADVERTENCIA;
    blk_n = BLOQUEO;
    act_n = 1'b0;
    ent_n = 1'b0;
    inc_n = 1'b0;
    fon_n = 1'b0;
`ifdef ATM_PIN_TIMEOUT_EN
    tmo_n = '0;
`endif
    case (state)
      ST_IDLE: if (TARJETA_RECIBIDA) begin
        bal_n = BALANCE_INICIAL;
        digits_n = '0;
        cnt_n = '0;
        state_n = ST_PIN_ENTRY;
      end
      // Card removal outranks a digit arriving in the same cycle.
      ST_PIN_ENTRY: if (!TARJETA_RECIBIDA) begin
        digits_n = '0;
        cnt_n = '0;
        state_n = ST_IDLE;
      end else if (digito_edge) begin
        digits_n = {digits[11:0], DIGITO};
        cnt_n = dig_cnt + 2'd1;
        if (dig_cnt == 2'd3) state_n = ST_CHECK_PIN;
      end
`ifdef ATM_PIN_TIMEOUT_EN
      else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
        digits_n = '0;
        cnt_n = '0;
      end else begin
        tmo_n = tmo_cnt + 1'b1;
      end
`endif
      ST_CHECK_PIN: begin
        digits_n = '0;
        cnt_n = '0;
        if (digits == PIN) begin
          att_n = '0;
          adv_n = 1'b0;
          state_n = ST_WAIT_TRANS;
        end else begin
          inc_n = 1'b1;
          att_n = attempts + 2'd1;
          if (attempts == 2'd2) begin
            blk_n = 1'b1;
            state_n = ST_BLOCKED;
          end else begin
            if (attempts == 2'd1) adv_n = 1'b1;
            state_n = ST_PIN_ENTRY;
          end
        end
      end
      ST_WAIT_TRANS: if (!TARJETA_RECIBIDA) begin
        state_n = ST_IDLE;
      end else if (monto_edge) begin
        monto_n = MONTO;
        tipo_n = TIPO_TRANS;
        state_n = ST_EXEC;
      end
      ST_EXEC: begin
        if (!tipo_r) begin
          bal_n = BALANCE + {32'b0, monto_r};
          act_n = 1'b1;
        end else if ({32'b0, monto_r} <= BALANCE) begin
          bal_n = BALANCE - {32'b0, monto_r};
          act_n = 1'b1;
          ent_n = 1'b1;
        end else begin
          fon_n = 1'b1;
        end
        state_n = ST_DONE;
      end
      ST_DONE: if (!TARJETA_RECIBIDA) state_n = ST_IDLE;
      ST_BLOCKED: ;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      digito_q <= 1'b0;
      monto_q <= 1'b0;
      digits <= '0;
      dig_cnt <= '0;
      attempts <= '0;
      monto_r <= '0;
      tipo_r <= 1'b0;
      BALANCE <= '0;
      BALANCE_ACTUALIZADO <= 1'b0;
      ENTREGAR_DINERO <= 1'b0;
      PIN_INCORRECTO <= 1'b0;
      ADVERTENCIA <= 1'b0;
      BLOQUEO <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
`ifdef ATM_PIN_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      state <= state_n;
      digito_q <= DIGITO_STB;
      monto_q <= MONTO_STB;
      digits <= digits_n;
      dig_cnt <= cnt_n;
      attempts <= att_n;
      monto_r <= monto_n;
      tipo_r <= tipo_n;
      BALANCE <= bal_n;
      BALANCE_ACTUALIZADO <= act_n;
      ENTREGAR_DINERO <= ent_n;
      PIN_INCORRECTO <= inc_n;
      ADVERTENCIA <= adv_n;
      BLOQUEO <= blk_n;
      FONDOS_INSUFICIENTES <= fon_n;
`ifdef ATM_PIN_TIMEOUT_EN
      tmo_cnt <= tmo_n;
`endif
    end
  end

endmodule

// File: tb/tb_atm_controller.sv
// tb/tb_atm_controller.sv - table-driven bench for atm_controller
// Timeout sequence runs only when ATM_PIN_TIMEOUT_EN is defined.
module tb_atm_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        TARJETA_RECIBIDA = 1'b0;
  logic        TIPO_TRANS = 1'b0;
  logic        MONTO_STB = 1'b0;
  logic        DIGITO_STB = 1'b0;
  logic [3:0]  DIGITO = '0;
  logic [15:0] PIN = 16'h3761;
  logic [31:0] MONTO = '0;
  logic [63:0] BALANCE_INICIAL = '0;
  logic [63:0] BALANCE;
  logic        BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO;
  logic        ADVERTENCIA, BLOQUEO, FONDOS_INSUFICIENTES;

  atm_controller dut (
    .clk(clk), .rst(rst), .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .TIPO_TRANS(TIPO_TRANS),
    .MONTO_STB(MONTO_STB), .DIGITO_STB(DIGITO_STB), .DIGITO(DIGITO), .PIN(PIN),
    .MONTO(MONTO), .BALANCE_INICIAL(BALANCE_INICIAL), .BALANCE(BALANCE),
    .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO), .ENTREGAR_DINERO(ENTREGAR_DINERO),
    .PIN_INCORRECTO(PIN_INCORRECTO), .ADVERTENCIA(ADVERTENCIA), .BLOQUEO(BLOQUEO),
    .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES)
  );

  always #5 clk = ~clk;

  int n_act = 0, n_ent = 0, n_inc = 0, n_fon = 0;
  always @(negedge clk) begin
    if (BALANCE_ACTUALIZADO) n_act++;
    if (ENTREGAR_DINERO) n_ent++;
    if (PIN_INCORRECTO) n_inc++;
    if (FONDOS_INSUFICIENTES) n_fon++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic digit(input logic [3:0] d);
    @(negedge clk);
    DIGITO = d;
    DIGITO_STB = 1'b1;
    @(negedge clk);
    DIGITO_STB = 1'b0;
  endtask

  task automatic pin4(input logic [15:0] p);
    for (int k = 0; k < 4; k++) digit(p[15-4*k -: 4]);
  endtask

  task automatic amount(input logic tipo, input logic [31:0] m, input int len);
    @(negedge clk);
    TIPO_TRANS = tipo;
    MONTO = m;
    MONTO_STB = 1'b1;
    cycles(len);
    MONTO_STB = 1'b0;
  endtask

  typedef struct {
    logic [63:0] bal0;
    logic [15:0] dig;
    logic        tipo;
    logic [31:0] monto;
    int          len;
    logic [63:0] e_bal;
    int          e_act, e_ent, e_fon, e_inc;
    logic        e_adv, e_blk;
  } vec_t;

  vec_t vecs[10];

  task automatic run_session(input vec_t v);
    int a0, e0, f0, i0;
    a0 = n_act; e0 = n_ent; f0 = n_fon; i0 = n_inc;
    BALANCE_INICIAL = v.bal0;
    @(negedge clk);
    TARJETA_RECIBIDA = 1'b1;
    cycles(2);
    pin4(v.dig);
    cycles(3);
    if (v.len > 0) begin
      amount(v.tipo, v.monto, v.len);
      cycles(4);
    end
    chk("balance", BALANCE, v.e_bal);
    chk("actualizado_pulses", 64'(n_act - a0), 64'(v.e_act));
    chk("entregar_pulses", 64'(n_ent - e0), 64'(v.e_ent));
    chk("fondos_pulses", 64'(n_fon - f0), 64'(v.e_fon));
    chk("pin_incorrecto_pulses", 64'(n_inc - i0), 64'(v.e_inc));
    chk("advertencia", 64'(ADVERTENCIA), 64'(v.e_adv));
    chk("bloqueo", 64'(BLOQUEO), 64'(v.e_blk));
    TARJETA_RECIBIDA = 1'b0;
    cycles(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, i0;
    //              bal0                   dig      tipo monto  len e_bal                  act ent fon inc adv blk
    vecs[0] = '{64'd10000,             16'h3761, 1'b0, 32'd2000,  2, 64'd12000,            1, 0, 0, 0, 1'b0, 1'b0};
    vecs[1] = '{64'd10000,             16'h3761, 1'b1, 32'd2500,  1, 64'd7500,             1, 1, 0, 0, 1'b0, 1'b0};
    vecs[2] = '{64'd7500,              16'h3761, 1'b1, 32'd7500,  3, 64'd0,                1, 1, 0, 0, 1'b0, 1'b0};
    vecs[3] = '{64'd10000,             16'h3761, 1'b1, 32'd15000, 1, 64'd10000,            0, 0, 1, 0, 1'b0, 1'b0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFF0, 16'h3761, 1'b0, 32'h20,  1, 64'h10,               1, 0, 0, 0, 1'b0, 1'b0};
    vecs[5] = '{64'd300,               16'h1111, 1'b0, 32'd0,     0, 64'd300,              0, 0, 0, 1, 1'b0, 1'b0};
    vecs[6] = '{64'd100,               16'h3761, 1'b0, 32'd5,     1, 64'd105,              1, 0, 0, 0, 1'b0, 1'b0};
    vecs[7] = '{64'd500,               16'h1111, 1'b0, 32'd0,     0, 64'd500,              0, 0, 0, 1, 1'b0, 1'b0};
    vecs[8] = '{64'd600,               16'h2222, 1'b0, 32'd0,     0, 64'd600,              0, 0, 0, 1, 1'b1, 1'b0};
    vecs[9] = '{64'd777,               16'h4444, 1'b0, 32'd0,     0, 64'd777,              0, 0, 0, 1, 1'b1, 1'b1};

    cycles(3);
    chk("reset_balance", BALANCE, 64'd0);
    chk("reset_outputs", {58'd0, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO,
                          ADVERTENCIA, BLOQUEO, FONDOS_INSUFICIENTES}, 64'd0);
    rst = 1'b1;
    cycles(2);

    for (int i = 0; i < 10; i++) run_session(vecs[i]);

    // Locked out: correct PIN and an amount strobe must be ignored
    a0 = n_act; i0 = n_inc;
    TARJETA_RECIBIDA = 1'b1;
    cycles(2);
    pin4(16'h3761);
    cycles(3);
    amount(1'b0, 32'd1000, 1);
    cycles(4);
    chk("blocked_balance", BALANCE, 64'd777);
    chk("blocked_act", 64'(n_act - a0), 64'd0);
    chk("blocked_inc", 64'(n_inc - i0), 64'd0);
    chk("blocked_level", 64'(BLOQUEO), 64'd1);
    TARJETA_RECIBIDA = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #2;
    chk("async_reset_outputs", {BALANCE, 2'b00, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO,
                                ADVERTENCIA, BLOQUEO, FONDOS_INSUFICIENTES}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cycles(2);

    // Reset mid-PIN, then a full correct PIN; checks transaction latency
    BALANCE_INICIAL = 64'd50;
    TARJETA_RECIBIDA = 1'b1;
    cycles(2);
    digit(4'h3);
    digit(4'h7);
    #2 rst = 1'b0;
    #2 chk("midpin_reset_balance", BALANCE, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    pin4(16'h3761);
    cycles(3);
    a0 = n_act;
    @(negedge clk);
    TIPO_TRANS = 1'b0;
    MONTO = 32'd1;
    MONTO_STB = 1'b1;
    @(negedge clk);
    chk("exec_latency_before", BALANCE, 64'd50);
    MONTO_STB = 1'b0;
    @(negedge clk);
    chk("exec_latency_after", BALANCE, 64'd51);
    chk("exec_pulse_high", 64'(BALANCE_ACTUALIZADO), 64'd1);
    @(negedge clk);
    chk("exec_pulse_low", 64'(BALANCE_ACTUALIZADO), 64'd0);
    amount(1'b0, 32'd1, 1);
    cycles(4);
    chk("one_txn_per_session", BALANCE, 64'd51);
    chk("one_txn_pulses", 64'(n_act - a0), 64'd1);
    TARJETA_RECIBIDA = 1'b0;
    cycles(3);

    // Card removed mid-PIN; stray amount strobe in PIN entry is ignored
    BALANCE_INICIAL = 64'd200;
    i0 = n_inc;
    TARJETA_RECIBIDA = 1'b1;
    cycles(2);
    digit(4'h3);
    digit(4'h7);
    amount(1'b0, 32'd9, 1);
    TARJETA_RECIBIDA = 1'b0;
    cycles(2);
    TARJETA_RECIBIDA = 1'b1;
    cycles(2);
    pin4(16'h3761);
    cycles(3);
    amount(1'b1, 32'd200, 2);
    cycles(4);
    chk("card_removed_balance", BALANCE, 64'd0);
    chk("card_removed_inc", 64'(n_inc - i0), 64'd0);
    TARJETA_RECIBIDA = 1'b0;
    cycles(3);

    // PIN check latency on a wrong PIN
    TARJETA_RECIBIDA = 1'b1;
    cycles(2);
    digit(4'h9);
    digit(4'h9);
    digit(4'h9);
    @(negedge clk);
    DIGITO = 4'h9;
    DIGITO_STB = 1'b1;
    @(negedge clk);
    chk("pin_latency_before", 64'(PIN_INCORRECTO), 64'd0);
    DIGITO_STB = 1'b0;
    @(negedge clk);
    chk("pin_latency_after", 64'(PIN_INCORRECTO), 64'd1);
    @(negedge clk);
    chk("pin_pulse_low", 64'(PIN_INCORRECTO), 64'd0);
    TARJETA_RECIBIDA = 1'b0;
    cycles(3);

`ifdef ATM_PIN_TIMEOUT_EN
    BALANCE_INICIAL = 64'd40;
    i0 = n_inc;
    TARJETA_RECIBIDA = 1'b1;
    cycles(2);
    digit(4'h3);
    digit(4'h7);
    cycles(1010);
    pin4(16'h3761);
    cycles(3);
    amount(1'b0, 32'd2, 1);
    cycles(4);
    chk("timeout_balance", BALANCE, 64'd42);
    chk("timeout_inc", 64'(n_inc - i0), 64'd0);
    TARJETA_RECIBIDA = 1'b0;
    cycles(3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
